// File: rtl/pipe_ctrl_unit_if.sv
// Control-path bus of pipe_ctrl_unit: ID-stage instruction fields and pipeline
// control inputs, plus the control bundles carried by the ID/EX, EX/MEM and MEM/WB
// registers and the hazard/diagnostic outputs.
interface pipe_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              en;
  logic [5:0]        opc_id;
  logic [REG_AW-1:0] rs_id;
  logic [REG_AW-1:0] rt_id;
  logic              flush;
  logic [1:0]        ex_wb;
  logic [2:0]        ex_m;
  logic [3:0]        ex_ex;
  logic [REG_AW-1:0] ex_rt;
  logic [1:0]        mem_wb;
  logic [2:0]        mem_m;
  logic [1:0]        wb_wb;
  logic              stall;
  logic              illegal_id;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output en, opc_id, rs_id, rt_id, flush,
    input  ex_wb, ex_m, ex_ex, ex_rt, mem_wb, mem_m, wb_wb, stall, illegal_id, stall_cnt
  );

  modport slave (
    input  en, opc_id, rs_id, rt_id, flush,
    output ex_wb, ex_m, ex_ex, ex_rt, mem_wb, mem_m, wb_wb, stall, illegal_id, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit. Decodes the ID opcode into WB/M/EX control bundles,
// carries them through ID/EX, EX/MEM and MEM/WB, detects load-use hazards and
// inserts bubbles on stall or branch flush, and counts stall cycles (saturating).
// Optional feature macro: PIPE_CTRL_IMM_EN adds addi (001000) and andi (001100)
// to the decoder; without it those opcodes are illegal.
module pipe_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst_n,
  pipe_ctrl_unit_if.slave bus
);

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
`ifdef PIPE_CTRL_IMM_EN
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
`endif

  localparam logic [REG_AW-1:0] RT_ZERO  = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);

  // Decoder results
  logic [1:0] dec_wb_s;
  logic [2:0] dec_m_s;
  logic [3:0] dec_ex_s;
  logic       dec_uses_rt_s;
  logic       dec_illegal_s;

  // Hazard
  logic       rs_hit_s;
  logic       rt_hit_s;
  logic       stall_s;

  // Pipeline control registers
  logic [1:0]        ex_wb_r;
  logic [2:0]        ex_m_r;
  logic [3:0]        ex_ex_r;
  logic [REG_AW-1:0] ex_rt_r;
  logic [1:0]        mem_wb_r;
  logic [2:0]        mem_m_r;
  logic [1:0]        wb_wb_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  // Opcode decode into {WB, M, EX} plus rt-usage and legality flags
  always_comb begin
    dec_wb_s      = 2'b00;
    dec_m_s       = 3'b000;
    dec_ex_s      = 4'b0000;
    dec_uses_rt_s = 1'b0;
    dec_illegal_s = 1'b0;
    case (bus.opc_id)
      OPC_RTYPE: begin
        dec_wb_s      = 2'b01;
        dec_ex_s      = 4'b0101;
        dec_uses_rt_s = 1'b1;
      end
      OPC_LW: begin
        dec_wb_s      = 2'b11;
        dec_m_s       = 3'b010;
        dec_ex_s      = 4'b1000;
      end
      OPC_SW: begin
        dec_m_s       = 3'b100;
        dec_ex_s      = 4'b1000;
        dec_uses_rt_s = 1'b1;
      end
      OPC_BEQ: begin
        dec_m_s       = 3'b001;
        dec_ex_s      = 4'b0010;
        dec_uses_rt_s = 1'b1;
      end
`ifdef PIPE_CTRL_IMM_EN
      OPC_ADDI: begin
        dec_wb_s      = 2'b01;
        dec_ex_s      = 4'b1000;
      end
      OPC_ANDI: begin
        dec_wb_s      = 2'b01;
        dec_ex_s      = 4'b1110;
      end
`endif
      default: begin
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  // Load-use hazard: a load in EX whose destination is read by the ID instruction
  always_comb begin
    rs_hit_s = (ex_rt_r == bus.rs_id);
    rt_hit_s = dec_uses_rt_s & (ex_rt_r == bus.rt_id);
    stall_s  = ex_m_r[1] & (ex_rt_r != RT_ZERO) & (rs_hit_s | rt_hit_s);
  end

  // Advance the ID/EX, EX/MEM and MEM/WB control registers; bubbles on stall/flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_wb_r  <= 2'b00;
      ex_m_r   <= 3'b000;
      ex_ex_r  <= 4'b0000;
      ex_rt_r  <= RT_ZERO;
      mem_wb_r <= 2'b00;
      mem_m_r  <= 3'b000;
      wb_wb_r  <= 2'b00;
    end else if (bus.en) begin
      if (stall_s | bus.flush) begin
        ex_wb_r <= 2'b00;
        ex_m_r  <= 3'b000;
        ex_ex_r <= 4'b0000;
        ex_rt_r <= RT_ZERO;
      end else begin
        ex_wb_r <= dec_wb_s;
        ex_m_r  <= dec_m_s;
        ex_ex_r <= dec_ex_s;
        ex_rt_r <= bus.rt_id;
      end
      if (bus.flush) begin
        mem_wb_r <= 2'b00;
        mem_m_r  <= 3'b000;
      end else begin
        mem_wb_r <= ex_wb_r;
        mem_m_r  <= ex_m_r;
      end
      wb_wb_r <= mem_wb_r;
    end
  end

  // Saturating count of cycles actually spent stalled (a flush overrides the stall)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.en & stall_s & ~bus.flush & (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end
  end

  assign bus.ex_wb      = ex_wb_r;
  assign bus.ex_m       = ex_m_r;
  assign bus.ex_ex      = ex_ex_r;
  assign bus.ex_rt      = ex_rt_r;
  assign bus.mem_wb     = mem_wb_r;
  assign bus.mem_m      = mem_m_r;
  assign bus.wb_wb      = wb_wb_r;
  assign bus.stall      = stall_s;
  assign bus.illegal_id = dec_illegal_s;
  assign bus.stall_cnt  = stall_cnt_r;

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

- Pipelined MIPS control unit: decodes the ID-stage opcode into the WB/M/EX control bundles.
- Carries the bundles through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and inserts bubbles on stall or branch flush.
- Sits between the IF/ID register and the datapath stage registers; datapath fields (data, immediates) stay outside.

## Interface
Parameters:
- REG_AW, 5, register-address width for hazard compare.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  pipeline advance enable; 0 = every register holds.
- opc_id  in  6  opcode of the instruction in ID.
- rs_id  in  REG_AW  rs field of the ID instruction.
- rt_id  in  REG_AW  rt field of the ID instruction.
- flush  in  1  branch taken, resolved in MEM.
- ex_wb  out  2  ID/EX WB bundle.
- ex_m  out  3  ID/EX M bundle.
- ex_ex  out  4  ID/EX EX bundle.
- ex_rt  out  REG_AW  ID/EX registered rt.
- mem_wb  out  2  EX/MEM WB bundle.
- mem_m  out  3  EX/MEM M bundle.
- wb_wb  out  2  MEM/WB WB bundle.
- stall  out  1  load-use hazard; combinational; drives PC/IF-ID hold.
- illegal_id  out  1  combinational; ID opcode undecoded.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
Bundle layout:
- WB: [0] RegWrite, [1] MemToReg.
- M: [0] Branch, [1] MemRead, [2] MemWrite.
- EX: [0] RegDst, [2:1] ALUOp, [3] ALUSrc.

Decode, as {WB, M, EX}:
- R-type 000000 -> 01, 000, 0101.
- lw 100011 -> 11, 010, 1000.
- sw 101011 -> 00, 100, 1000.
- beq 000100 -> 00, 001, 0010.
- Any other opcode -> all zeros, illegal_id=1.

Hazard detection:
- stall = ex_m[1] & (ex_rt != 0) & (ex_rt==rs_id | (uses_rt & ex_rt==rt_id)).
- uses_rt = 1 for R-type, sw and beq only.
- stall is computed from the ID inputs independent of en; it is acted on only on edges where en=1.

Register update when en=1:
- ID/EX (bundles and ex_rt) loads all zeros if stall|flush; otherwise it loads the decode result and rt_id.
- EX/MEM loads zeros if flush; otherwise it loads ex_wb/ex_m.
- MEM/WB loads mem_wb unconditionally.
- flush and stall in the same cycle: flush rules apply; the bubble is identical.

Stall counter:
- Increments on each edge with en & stall & ~flush.
- Saturates at 2^CNT_W-1.

Reset:
- All registered outputs and stall_cnt go to 0 immediately on rst_n low.
- Reset mid-stream discards all in-flight bundles.
- After reset, stall=0 because ex_m=0.

## Timing
- Decode to ex_*: 1 cycle. To mem_*: 2 cycles. To wb_wb: 3 cycles (each counted in en=1 edges).
- stall and illegal_id are same-cycle combinational; there are no other combinational in-to-out paths.
- en=0 freezes every register including stall_cnt; stall continues to reflect its inputs.
- A load-use stall lasts exactly one en=1 cycle: the bubble clears ex_m[1].

## Configuration
- PIPE_CTRL_IMM_EN defined: decode adds two opcodes.
  - addi 001000 -> 01, 000, 1000.
  - andi 001100 -> 01, 000, 1110.
  - Both have uses_rt=0.
- PIPE_CTRL_IMM_EN undefined: both opcodes are illegal (zero bundle, illegal_id=1).

## Test plan
- Reset: hold rst_n=0 with opc_id=100011 and clk running -> all bundles 0, stall_cnt=0, stall=0.
- lw stream: opc_id=100011, en=1 -> ex={11,010,1000} after 1 edge; mem_wb=11, mem_m=010 after 2 edges; wb_wb=11 after 3 edges.
- Load-use, stall path: lw rt=5, then R-type rs=5 -> stall=1 for one cycle, ID/EX=0 next, stall_cnt=1.
- Load-use, no-stall cases:
  - ex_rt=0 -> stall=0.
  - lw rt=5 followed by lw rt=5 -> stall=0, since lw has uses_rt=0.
- Flush: flush=1 with ID=beq and EX=sw -> ex_* and mem_* become 0 next edge; wb_wb takes the old mem_wb.
- Saturation/enable with CNT_W=2: four stall cycles -> stall_cnt=3. With en=0 and stall=1 -> stall_cnt and all bundles unchanged.
- Macro: opc_id=001000 -> with PIPE_CTRL_IMM_EN, ex={01,000,1000}, illegal_id=0; without it, ex=0, illegal_id=1.
